// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// The result registers are separate from the working registers, so outputs hold the last result while a division runs.
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one restoring iteration per edge, MSB first, 2N edges in total
// DONE  | done pulses for one cycle; results valid; returns to IDLE
module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] q_reg;
  logic [N-1:0]   d_reg;
  logic [N-1:0]   p_reg;
  logic [CW-1:0]  count;

  logic [N:0]     p_shift;
  logic           fits;
  logic [N-1:0]   p_next;
  logic [2*N-1:0] q_next;

  // A restored partial remainder is always below the divisor, so N bits hold it
  // between iterations; only the shifted value needs the extra bit.
  always_comb begin
    p_shift = {p_reg, q_reg[2*N-1]};
    fits    = (p_shift >= {1'b0, d_reg});
    p_next  = fits ? N'(p_shift - {1'b0, d_reg}) : p_shift[N-1:0];
    q_next  = {q_reg[2*N-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      p_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            p_reg <= '0;
            count <= '0;
            busy  <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          p_reg <= p_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= p_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
